// File: rtl/bus_slave_decoder.sv
// bus_slave_decoder
//   Master-side address decoder and data-phase tracker for the 16-slot
//   system bus. The address phase is decoded into a one-hot slave select.
//   The select is then registered into the data phase and held until the
//   slave completes. A watchdog aborts data phases that stall for too long.
//
//   Handshake: an address phase transfers on a CLK edge where MsREQ = 1 and
//   MsACK = 1. MsACK is combinational, so the master keeps MsREQ/MsWR/MsADDR
//   stable until it sees MsACK. A data phase completes on the first edge
//   with DpVLD = 1 and MsRDY = 1. MsRDY is ignored while DpVLD = 0.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   MsREQ/MsWR/MsADDR  address phase from the master
//   MsRDY/MsERR     data-phase ready/error from the read mux (MsERR unused)
//   MsACK           address phase accepted this cycle
//   SxSEL           one-hot select of the accepted address phase, else 0
//   DmRMUX          registered data-phase one-hot select for the read mux
//   DpVLD/DpWR/DpUMP  data phase valid, write flag, unmapped-region flag
//   TmoABT          one-cycle watchdog abort pulse
//   TmoFLG/TmoCLR   sticky timeout flag and its clear
//   TmoSLV          region index of the last timed-out slave
//   DbgST           current FSM state, for observation only
module bus_slave_decoder #(
    parameter int          AW      = 32,
    parameter logic [15:0] SLV_MAP = 16'hFFFF,
    parameter int          TMO_CYC = 256,
    parameter int          TW      = 9
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          MsREQ,
    input  logic          MsWR,
    input  logic [AW-1:0] MsADDR,
    input  logic          MsRDY,
    input  logic          MsERR,
    output logic          MsACK,
    output logic [15:0]   SxSEL,
    output logic [15:0]   DmRMUX,
    output logic          DpVLD,
    output logic          DpWR,
    output logic          DpUMP,
    output logic          TmoABT,
    output logic          TmoFLG,
    output logic [3:0]    TmoSLV,
    input  logic          TmoCLR,
    output logic [1:0]    DbgST
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam bit          TMO_EN   = (TMO_CYC != 0);
    // Meaningless when the watchdog is disabled; TMO_EN masks it then.
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    state_t        r_state;
    logic [15:0]   r_dmrmux;
    logic          r_dp_vld;
    logic          r_dp_wr;
    logic          r_dp_ump;
    logic          r_tmo_abt;
    logic          r_tmo_flg;
    logic [3:0]    r_tmo_slv;
    logic [TW-1:0] r_cnt;

    logic [3:0]    w_idx;
    logic          w_mapped;
    logic [15:0]   w_sel;
    logic          w_tmo_hit;
    logic          w_ack;
    logic [3:0]    w_cur_idx;
    logic          w_unused;

    // Only the region bits matter; MsERR is answered by the slaves themselves.
    assign w_unused = ^{MsERR, MsADDR[AW-5:0]};

    assign w_idx    = MsADDR[AW-1:AW-4];
    assign w_mapped = SLV_MAP[w_idx];

    // Unpopulated regions fall back to the default slave in slot 0.
    always_comb begin
        w_sel = 16'h0001;
        if (w_mapped) begin
            w_sel = 16'h0001 << w_idx;
        end
    end

    // Fires in the stall cycle that would make the phase TMO_CYC long.
    assign w_tmo_hit = r_dp_vld & ~MsRDY & TMO_EN & (r_cnt == TMO_LAST);

    // ABORT has DpVLD = 0, so its state term is what keeps MsACK low there.
    assign w_ack = MsREQ & (~r_dp_vld | MsRDY) & ~w_tmo_hit & (r_state != ST_ABORT);

    // One-hot to index of the slave currently owning the data phase.
    always_comb begin
        w_cur_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (r_dmrmux[i]) begin
                w_cur_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_dmrmux  <= 16'h0001;
            r_dp_vld  <= 1'b0;
            r_dp_wr   <= 1'b0;
            r_dp_ump  <= 1'b0;
            r_tmo_abt <= 1'b0;
            r_tmo_flg <= 1'b0;
            r_tmo_slv <= 4'd0;
            r_cnt     <= '0;
        end else begin
            r_tmo_abt <= 1'b0;
            if (TmoCLR) begin
                r_tmo_flg <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_ack) begin
                        r_state  <= ST_DATA;
                        r_dmrmux <= w_sel;
                        r_dp_vld <= 1'b1;
                        r_dp_wr  <= MsWR;
                        r_dp_ump <= ~w_mapped;
                        r_cnt    <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_tmo_hit) begin
                        // Written after the clear above, so a new abort wins.
                        r_state   <= ST_ABORT;
                        r_tmo_abt <= 1'b1;
                        r_tmo_flg <= 1'b1;
                        r_tmo_slv <= w_cur_idx;
                        r_dmrmux  <= 16'h0001;
                        r_dp_vld  <= 1'b0;
                        r_dp_wr   <= 1'b0;
                        r_dp_ump  <= 1'b0;
                    end else if (MsRDY) begin
                        if (w_ack) begin
                            // Pipelined: next phase follows with no bubble.
                            r_dmrmux <= w_sel;
                            r_dp_wr  <= MsWR;
                            r_dp_ump <= ~w_mapped;
                            r_cnt    <= '0;
                        end else begin
                            // DmRMUX intentionally keeps the last select.
                            r_state  <= ST_IDLE;
                            r_dp_vld <= 1'b0;
                            r_dp_wr  <= 1'b0;
                            r_dp_ump <= 1'b0;
                        end
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_ABORT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign MsACK  = w_ack;
    assign SxSEL  = w_ack ? w_sel : 16'h0000;
    assign DmRMUX = r_dmrmux;
    assign DpVLD  = r_dp_vld;
    assign DpWR   = r_dp_wr;
    assign DpUMP  = r_dp_ump;
    assign TmoABT = r_tmo_abt;
    assign TmoFLG = r_tmo_flg;
    assign TmoSLV = r_tmo_slv;
    assign DbgST  = r_state;

endmodule

// File: tb/tb_bus_slave_decoder.sv
// tb_bus_slave_decoder
//   Three decoder instances with different region maps and watchdog limits
//   share one stimulus stream. A transaction-level model predicts the
//   combinational handshake outputs each cycle and the registered outputs
//   after each edge; the registered predictions go through exp_q to a
//   separate monitor.
module tb_bus_slave_decoder;

    localparam int          NI = 3;
    localparam int          VW = 25;
    localparam logic [15:0] C_MAP [NI] = '{16'hFFFF, 16'h00FF, 16'h5A5F};
    localparam int          C_TMO [NI] = '{4, 6, 0};

    logic        CLK;
    logic        RST;
    logic        MsREQ;
    logic        MsWR;
    logic [31:0] MsADDR;
    logic        MsRDY;
    logic        MsERR;
    logic        TmoCLR;

    logic        ack_o [NI];
    logic [15:0] sx_o  [NI];
    logic [15:0] dm_o  [NI];
    logic        vld_o [NI];
    logic        wr_o  [NI];
    logic        ump_o [NI];
    logic        abt_o [NI];
    logic        flg_o [NI];
    logic [3:0]  slv_o [NI];
    logic [1:0]  st_o  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bus_slave_decoder #(
            .AW      (32),
            .SLV_MAP (C_MAP[g]),
            .TMO_CYC (C_TMO[g]),
            .TW      (9)
        ) u_dut (
            .CLK    (CLK),
            .RST    (RST),
            .MsREQ  (MsREQ),
            .MsWR   (MsWR),
            .MsADDR (MsADDR),
            .MsRDY  (MsRDY),
            .MsERR  (MsERR),
            .MsACK  (ack_o[g]),
            .SxSEL  (sx_o[g]),
            .DmRMUX (dm_o[g]),
            .DpVLD  (vld_o[g]),
            .DpWR   (wr_o[g]),
            .DpUMP  (ump_o[g]),
            .TmoABT (abt_o[g]),
            .TmoFLG (flg_o[g]),
            .TmoSLV (slv_o[g]),
            .TmoCLR (TmoCLR),
            .DbgST  (st_o[g])
        );
    end

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- scoreboard state ----------------
    logic [NI*VW-1:0] exp_q [$];
    int n_chk = 0;
    int n_err = 0;

    // Reference model: one record per instance describing the open phase.
    bit m_vld   [NI];  // a data phase is open
    int m_reg   [NI];  // region owning the read mux
    bit m_wr    [NI];
    bit m_ump   [NI];
    int m_stall [NI];  // stalled cycles seen by the open phase
    bit m_abt   [NI];  // this cycle is the abort cycle
    bit m_flg   [NI];
    int m_slv   [NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
        end
    endtask

    // Drive one cycle of inputs, check the combinational response and
    // queue the registered outputs expected after the coming edge.
    task automatic cyc(input bit rst, input bit req, input bit wr,
                       input logic [31:0] addr, input bit rdy, input bit clr);
        logic [NI*VW-1:0] e;
        @(negedge CLK);
        RST    = rst;
        MsREQ  = req;
        MsWR   = wr;
        MsADDR = addr;
        MsRDY  = rdy;
        TmoCLR = clr;
        MsERR  = 1'($urandom_range(0, 1));
        #1;
        e = '0;
        for (int k = 0; k < NI; k++) begin
            int          region;
            bit          mapped;
            logic [15:0] sel;
            bit          hit;
            bit          ack;
            region = int'(addr[31:28]);
            mapped = C_MAP[k][region];
            sel    = mapped ? 16'(1 << region) : 16'h0001;
            hit    = m_vld[k] && !rdy && (C_TMO[k] != 0) && (m_stall[k] + 1 == C_TMO[k]);
            ack    = req && (!m_vld[k] || rdy) && !hit && !m_abt[k];
            if (!rst) begin
                chk($sformatf("ack[%0d]", k), 32'(ack_o[k]), 32'(ack));
                chk($sformatf("sxsel[%0d]", k), 32'(sx_o[k]), ack ? 32'(sel) : 32'd0);
            end
            if (rst) begin
                m_vld[k] = 0; m_reg[k] = 0; m_wr[k] = 0; m_ump[k] = 0;
                m_stall[k] = 0; m_abt[k] = 0; m_flg[k] = 0; m_slv[k] = 0;
            end else if (hit) begin
                m_abt[k] = 1; m_flg[k] = 1; m_slv[k] = m_reg[k];
                m_vld[k] = 0; m_reg[k] = 0; m_wr[k] = 0; m_ump[k] = 0;
            end else begin
                m_abt[k] = 0;
                if (clr) m_flg[k] = 0;
                if (ack) begin
                    m_vld[k] = 1; m_reg[k] = mapped ? region : 0;
                    m_wr[k] = wr; m_ump[k] = !mapped; m_stall[k] = 0;
                end else if (m_vld[k] && rdy) begin
                    m_vld[k] = 0; m_wr[k] = 0; m_ump[k] = 0;
                end else if (m_vld[k]) begin
                    m_stall[k]++;
                end
            end
            e[k*VW +: VW] = {16'(1 << m_reg[k]), m_vld[k], m_wr[k], m_ump[k],
                             m_abt[k], m_flg[k], 4'(m_slv[k])};
        end
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                logic [NI*VW-1:0] e;
                logic [VW-1:0]    act;
                e = exp_q.pop_front();
                for (int k = 0; k < NI; k++) begin
                    act = {dm_o[k], vld_o[k], wr_o[k], ump_o[k], abt_o[k], flg_o[k], slv_o[k]};
                    chk($sformatf("regs[%0d]{mux,vld,wr,ump,abt,flg,slv}", k),
                        32'(act), 32'(e[k*VW +: VW]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b1; MsREQ = 1'b0; MsWR = 1'b0; MsADDR = '0;
        MsRDY = 1'b0; MsERR = 1'b0; TmoCLR = 1'b0;

        cyc(1, 0, 0, 32'h0, 0, 0);
        cyc(1, 1, 0, 32'h0, 0, 0);
        cyc(0, 1, 0, 32'h4000_0000, 0, 0);
        chk("rst_dmrmux", 32'(dm_o[0]), 32'h0001);
        chk("rst_dpvld", 32'(vld_o[0]), 32'd0);
        chk("rst_ack_eq_req", 32'(ack_o[0]), 32'd1);
        chk("rst_tmoflg", 32'(flg_o[0]), 32'd0);
        cyc(0, 0, 0, 32'h0, 1, 0);   // finish that phase

        // Single read to region 3.
        cyc(0, 1, 0, 32'h3000_0010, 1, 0);
        chk("rd3_sxsel", 32'(sx_o[0]), 32'h0008);
        cyc(0, 0, 0, 32'h0, 1, 0);
        chk("rd3_dmrmux", 32'(dm_o[0]), 32'h0008);
        chk("rd3_dpvld", 32'(vld_o[0]), 32'd1);
        cyc(0, 0, 0, 32'h0, 1, 0);
        chk("rd3_idle", 32'(vld_o[0]), 32'd0);

        // Back-to-back to regions 1 and 15, then a three-cycle stall.
        cyc(0, 1, 0, 32'h1234_5678, 1, 0);
        cyc(0, 1, 0, 32'hF000_0004, 1, 0);
        chk("b2b_dmrmux1", 32'(dm_o[0]), 32'h0002);
        chk("b2b_ack2", 32'(ack_o[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 32'h2000_0000, 0, 0);
            chk("stall_dmrmux", 32'(dm_o[0]), 32'h8000);
            chk("stall_dpvld", 32'(vld_o[0]), 32'd1);
            chk("stall_ack", 32'(ack_o[0]), 32'd0);
            chk("stall_sxsel", 32'(sx_o[0]), 32'd0);
        end

        // Reset in the very cycle the watchdog of instance 0 would fire.
        cyc(1, 0, 0, 32'h0, 0, 0);
        chk("rstdata_vld_before", 32'(vld_o[0]), 32'd1);
        cyc(0, 0, 0, 32'h0, 0, 0);
        chk("rstdata_vld", 32'(vld_o[0]), 32'd0);
        chk("rstdata_abt", 32'(abt_o[0]), 32'd0);
        chk("rstdata_dmrmux", 32'(dm_o[0]), 32'h0001);

        // Unmapped write on the 00FF-map instance.
        cyc(0, 1, 1, 32'hA000_0000, 1, 0);
        chk("umap_sxsel", 32'(sx_o[1]), 32'h0001);
        cyc(0, 0, 0, 32'h0, 1, 0);
        chk("umap_dmrmux", 32'(dm_o[1]), 32'h0001);
        chk("umap_dpump", 32'(ump_o[1]), 32'd1);
        chk("umap_dpwr", 32'(wr_o[1]), 32'd1);

        // Slave 5 never ready; instance 0 has TMO_CYC = 4.
        cyc(0, 1, 0, 32'h5000_0000, 0, 0);
        chk("tmo_sxsel", 32'(sx_o[0]), 32'h0020);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0, 32'h0, 0, 0);
            chk("tmo_wait_vld", 32'(vld_o[0]), 32'd1);
            chk("tmo_wait_abt", 32'(abt_o[0]), 32'd0);
        end
        cyc(0, 1, 0, 32'h6000_0000, 1, 0);
        chk("tmo_abt", 32'(abt_o[0]), 32'd1);
        chk("tmo_slv", 32'(slv_o[0]), 32'd5);
        chk("tmo_flg", 32'(flg_o[0]), 32'd1);
        chk("tmo_dmrmux", 32'(dm_o[0]), 32'h0001);
        chk("tmo_ack_forced0", 32'(ack_o[0]), 32'd0);
        cyc(0, 0, 0, 32'h0, 1, 1);
        chk("tmo_abt_pulse", 32'(abt_o[0]), 32'd0);
        cyc(0, 0, 0, 32'h0, 1, 0);
        chk("tmoclr_flg", 32'(flg_o[0]), 32'd0);
        chk("tmoclr_slv_kept", 32'(slv_o[0]), 32'd5);

        // Watchdog disabled on instance 2: a 1000-cycle stall never aborts.
        cyc(0, 1, 0, 32'h9000_0000, 1, 0);
        for (int i = 0; i < 1000; i++) begin
            cyc(0, 0, 0, 32'h0, 0, 0);
        end
        chk("notmo_vld", 32'(vld_o[2]), 32'd1);
        chk("notmo_dmrmux", 32'(dm_o[2]), 32'h0200);
        chk("notmo_flg", 32'(flg_o[2]), 32'd0);
        cyc(0, 0, 0, 32'h0, 1, 0);

        // Random traffic with a varying slave readiness per block.
        for (int b = 0; b < 30; b++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(15, 100);
            for (int i = 0; i < 100; i++) begin
                cyc($urandom_range(0, 199) == 0,
                    $urandom_range(0, 99) < 70,
                    1'($urandom_range(0, 1)),
                    $urandom,
                    $urandom_range(0, 99) < rdy_pct,
                    $urandom_range(0, 19) == 0);
            end
        end
        cyc(0, 0, 0, 32'h0, 1, 0);

        @(posedge CLK);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
